vga_v_timing_gen: RTL and testbench
===================================

Name: vga_v_timing_gen

Overview:
Vertical timing generator for the 640x480@60 VGA path. It counts horizontal line-end pulses and drives the vertical line count, the active-low VSYNC and the phase information consumed by the vertical display decoder. It sits between the horizontal timing generator and the vertical display/row logic, and owns the frame cadence of 525 lines.

Parameters:
V_SYNC, 2, lines with VSYNC asserted (low)
V_BACK, 33, back-porch lines
V_DISP, 480, visible lines
V_FRONT, 10, front-porch lines
CNT_W, 10, width of line counter and row outputs; V_SYNC+V_BACK+V_DISP+V_FRONT must be <= 2**CNT_W (elaboration-time assertion)

Ports:
clk  in  1  pixel clock (25.175 MHz nominal)
rst_n  in  1  asynchronous active-low reset
line_end  in  1  one-clk pulse from horizontal generator on the last pixel of each line
V_Counts  out  CNT_W  current line index, 0..TOTAL-1 (TOTAL = sum of the four V_* parameters, 525 by default)
VSYNC  out  1  vertical sync, active low, low exactly while in the SYNC phase
v_phase  out  2  current phase: 0 SYNC, 1 BACK, 2 DISP, 3 FRONT
v_active  out  1  high while in the DISP phase
Display_Row  out  CNT_W  visible row index 0..V_DISP-1 during DISP, 0 otherwise
frame_start  out  1  one-clk pulse on the cycle V_Counts wraps to 0

Behaviour:
- Reset (async assert, sync-release via the flops): V_Counts=0, v_phase=SYNC, VSYNC=0, v_active=0, Display_Row=0, frame_start=0.
- All outputs are registered and change only on a clk edge where line_end=1. Latency is one clk: line_end sampled at edge N gives new values visible after edge N.
- line_end=0: all outputs hold, and frame_start=0.
- Line counter: on line_end, V_Counts <= (V_Counts==TOTAL-1) ? 0 : V_Counts+1. frame_start=1 only for the cycle following that wrap, then 0.
- Phase FSM, advanced by line_end, with boundaries on the next count value:
  - SYNC lines 0..V_SYNC-1 (0..1)
  - BACK lines V_SYNC..V_SYNC+V_BACK-1 (2..34)
  - DISP lines 35..514
  - FRONT lines 515..524, then back to SYNC at the wrap to 0
- Phase is derived from the next count in the same registered update, so v_phase, VSYNC, v_active and V_Counts always agree in the same cycle. They are never skewed.
- VSYNC = (v_phase != SYNC). v_active = (v_phase == DISP).
- Display_Row:
  - resets to 0 on entry into DISP (line 35)
  - increments by 1 on each subsequent line_end within DISP, reaching V_DISP-1 (479) on line 514
  - forced to 0 in all other phases
  - It is counter-based, not combinational; width arithmetic is unsigned CNT_W with no overflow inside DISP.
- line_end held high for consecutive cycles: each high cycle counts as one line. No edge detection.
- Reset mid-frame: immediate return to reset values. Counting resumes from line 0 on the first line_end after release, and no frame_start is emitted for that partial frame.
- V_Counts outside 0..TOTAL-1 is unreachable. Any illegal state (for example from an upset) recovers to SYNC/0 on the next line_end.

Decomposition:
- Shared package vga_timing_pkg holds:
  - typedef enum logic [1:0] v_phase_t {V_SYNC_PH, V_BACK_PH, V_DISP_PH, V_FRONT_PH}
  - default vertical constants (2/33/480/10, TOTAL 525), alongside the horizontal constants (96/48/640/16, 800) for reuse by the H generator
- No sub-module: the counter and phase FSM are a single always_ff with a small next-state always_comb.

Test Plan:
- Reset: hold rst_n=0 and pulse line_end 5 times -> V_Counts=0, VSYNC=0, v_phase=0, v_active=0, Display_Row=0, frame_start never 1.
- Sync/back porch edges: release reset and issue 2 line_end -> V_Counts=2, VSYNC 0->1, v_phase=1. After 35 total pulses -> V_Counts=35, v_phase=2, v_active=1, Display_Row=0.
- Display span: continue to 514 total pulses -> V_Counts=514, Display_Row=479. Next pulse -> V_Counts=515, v_phase=3, v_active=0, Display_Row=0.
- Wrap: from V_Counts=524 pulse once -> V_Counts=0, VSYNC=0, frame_start=1 for exactly one clk. Over 3 full frames, frame_start pulses exactly 3 times, 525 pulses apart.
- Spacing: line_end every 800 clks vs back-to-back line_end on 4 consecutive clks -> V_Counts advances by exactly the number of high cycles, and outputs hold between pulses.
- Mid-frame reset: assert rst_n=0 asynchronously (between clk edges) at V_Counts=300 -> all outputs reach reset values without waiting for a clk edge. After release, the next pulse gives V_Counts=1, v_phase=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing definitions: phase encoding and default
// horizontal/vertical constants used by the H and V timing generators.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        V_SYNC_PH  = 2'd0,
        V_BACK_PH  = 2'd1,
        V_DISP_PH  = 2'd2,
        V_FRONT_PH = 2'd3
    } v_phase_t;

    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 48;
    localparam int H_DISP_DEF  = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF + H_DISP_DEF + H_FRONT_DEF;

    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 33;
    localparam int V_DISP_DEF  = 480;
    localparam int V_FRONT_DEF = 10;
    localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF + V_DISP_DEF + V_FRONT_DEF;

endpackage

// File: rtl/vga_v_timing_gen.sv
// Vertical timing generator: counts line_end pulses into a 525-line frame and
// produces registered line count, VSYNC, phase, display row and frame_start.
module vga_v_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FRONT = V_FRONT_DEF,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_end,
    output logic [CNT_W-1:0] V_Counts,
    output logic             VSYNC,
    output logic [1:0]       v_phase,
    output logic             v_active,
    output logic [CNT_W-1:0] Display_Row,
    output logic             frame_start
);

    localparam int TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    if (TOTAL > 2 ** CNT_W) begin : g_bad_cfg
        $error("vga_v_timing_gen: frame of %0d lines does not fit CNT_W=%0d", TOTAL, CNT_W);
    end

    localparam logic [CNT_W-1:0] LAST_LINE   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] DISP_START  = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(V_SYNC + V_BACK + V_DISP);

    function automatic v_phase_t phase_of(input logic [CNT_W-1:0] line);
        if (line < BACK_START)       return V_SYNC_PH;
        else if (line < DISP_START)  return V_BACK_PH;
        else if (line < FRONT_START) return V_DISP_PH;
        else                         return V_FRONT_PH;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] row_q, row_d;
    v_phase_t         phase_q, phase_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             fs_q, fs_d;

    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        cnt_d    = cnt_q;
        row_d    = row_q;
        phase_d  = phase_q;
        vsync_d  = vsync_q;
        active_d = active_q;
        fs_d     = 1'b0;

        if (line_end) begin
            // ">=" also folds any out-of-range count back to line 0
            if (cnt_q >= LAST_LINE) begin
                cnt_d = '0;
                fs_d  = (cnt_q == LAST_LINE);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            // Phase and its decodes come from the next count so all outputs
            // update together in the same edge.
            phase_d  = phase_of(cnt_d);
            vsync_d  = (phase_d != V_SYNC_PH);
            active_d = (phase_d == V_DISP_PH);

            if (phase_d == V_DISP_PH)
                row_d = (cnt_d == DISP_START) ? '0 : row_q + 1'b1;
            else
                row_d = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers sample
    // their _d values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            row_q    <= '0;
            phase_q  <= V_SYNC_PH;
            vsync_q  <= 1'b0;
            active_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            phase_q  <= phase_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            fs_q     <= fs_d;
        end
    end

    assign V_Counts    = cnt_q;
    assign VSYNC       = vsync_q;
    assign v_phase     = phase_q;
    assign v_active    = active_q;
    assign Display_Row = row_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_v_timing_gen.sv
// Self-checking bench for vga_v_timing_gen: directed frame landmarks plus
// randomized line_end traffic compared against an arithmetic line model.
module tb_vga_v_timing_gen;

    localparam int CNT_W = 10;
    localparam int TOTAL = 525;
    localparam int DISP0 = 35;
    localparam int FRNT0 = 515;

    logic             clk;
    logic             rst_n;
    logic             line_end;
    logic [CNT_W-1:0] V_Counts;
    logic             VSYNC;
    logic [1:0]       v_phase;
    logic             v_active;
    logic [CNT_W-1:0] Display_Row;
    logic             frame_start;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: line index and expected frame_start
    int m_cnt = 0;
    bit m_fs  = 1'b0;

    vga_v_timing_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_end    (line_end),
        .V_Counts    (V_Counts),
        .VSYNC       (VSYNC),
        .v_phase     (v_phase),
        .v_active    (v_active),
        .Display_Row (Display_Row),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_phase(input int c);
        if (c < 2)     return 0;
        if (c < DISP0) return 1;
        if (c < FRNT0) return 2;
        return 3;
    endfunction

    function automatic int exp_row(input int c);
        return (c >= DISP0 && c < FRNT0) ? c - DISP0 : 0;
    endfunction

    // one clock: drive line_end, advance the model at the edge, settle 1 ns
    task automatic step(input logic le);
        line_end = le;
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0;
            m_fs  = 1'b0;
        end else if (le) begin
            m_fs  = (m_cnt == TOTAL - 1);
            m_cnt = (m_cnt + 1) % TOTAL;
        end else begin
            m_fs = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            n_vec++;
            if (V_Counts !== '0 || VSYNC !== 1'b0 || v_phase !== 2'd0 ||
                v_active !== 1'b0 || Display_Row !== '0) begin
                n_err++;
                $display("FAIL reset_hold: cnt=%0d vs=%b ph=%0d act=%b row=%0d, want all 0",
                         V_Counts, VSYNC, v_phase, v_active, Display_Row);
            end
            n_vec++;
            if (frame_start !== 1'b0) begin
                n_err++;
                $display("FAIL reset_fs: frame_start=%b want 0", frame_start);
            end
        end
        line_end = 1'b0;
        rst_n    = 1'b1;
        step(1'b0);
    endtask

    task automatic test_porch_edges;
        step(1'b1);
        n_vec++;
        if (V_Counts !== 10'd1 || VSYNC !== 1'b0 || v_phase !== 2'd0) begin
            n_err++;
            $display("FAIL line1: cnt=%0d vs=%b ph=%0d want 1/0/0", V_Counts, VSYNC, v_phase);
        end
        step(1'b1);
        n_vec++;
        if (V_Counts !== 10'd2 || VSYNC !== 1'b1 || v_phase !== 2'd1) begin
            n_err++;
            $display("FAIL back_entry: cnt=%0d vs=%b ph=%0d want 2/1/1", V_Counts, VSYNC, v_phase);
        end
        for (int i = 2; i < 34; i++) step(1'b1);
        n_vec++;
        if (V_Counts !== 10'd34 || v_phase !== 2'd1 || v_active !== 1'b0) begin
            n_err++;
            $display("FAIL back_last: cnt=%0d ph=%0d act=%b want 34/1/0", V_Counts, v_phase, v_active);
        end
        step(1'b1);
        n_vec++;
        if (V_Counts !== 10'd35 || v_phase !== 2'd2 || v_active !== 1'b1 || Display_Row !== '0) begin
            n_err++;
            $display("FAIL disp_entry: cnt=%0d ph=%0d act=%b row=%0d want 35/2/1/0",
                     V_Counts, v_phase, v_active, Display_Row);
        end
    endtask

    task automatic test_display_span;
        for (int c = 36; c <= 514; c++) begin
            step(1'b1);
            n_vec++;
            if (Display_Row !== CNT_W'(c - DISP0) || v_active !== 1'b1) begin
                n_err++;
                $display("FAIL disp_row: line=%0d row=%0d act=%b want %0d/1",
                         c, Display_Row, v_active, c - DISP0);
            end
        end
        n_vec++;
        if (V_Counts !== 10'd514 || Display_Row !== 10'd479) begin
            n_err++;
            $display("FAIL disp_last: cnt=%0d row=%0d want 514/479", V_Counts, Display_Row);
        end
        step(1'b1);
        n_vec++;
        if (V_Counts !== 10'd515 || v_phase !== 2'd3 || v_active !== 1'b0 || Display_Row !== '0) begin
            n_err++;
            $display("FAIL front_entry: cnt=%0d ph=%0d act=%b row=%0d want 515/3/0/0",
                     V_Counts, v_phase, v_active, Display_Row);
        end
    endtask

    task automatic test_wrap;
        int fs_seen;
        int last_idx;
        for (int i = 0; i < TOTAL && m_cnt != TOTAL - 1; i++) step(1'b1);
        n_vec++;
        if (V_Counts !== 10'd524 || v_phase !== 2'd3 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pre: cnt=%0d ph=%0d fs=%b want 524/3/0", V_Counts, v_phase, frame_start);
        end
        step(1'b1);
        n_vec++;
        if (V_Counts !== '0 || VSYNC !== 1'b0 || v_phase !== 2'd0 || frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL wrap: cnt=%0d vs=%b ph=%0d fs=%b want 0/0/0/1",
                     V_Counts, VSYNC, v_phase, frame_start);
        end
        step(1'b0);
        n_vec++;
        if (frame_start !== 1'b0 || V_Counts !== '0) begin
            n_err++;
            $display("FAIL wrap_fs_len: fs=%b cnt=%0d want 0/0", frame_start, V_Counts);
        end
        fs_seen  = 0;
        last_idx = 0;
        for (int p = 1; p <= 3 * TOTAL; p++) begin
            step(1'b1);
            if (frame_start === 1'b1) begin
                fs_seen++;
                n_vec++;
                if (p - last_idx != TOTAL) begin
                    n_err++;
                    $display("FAIL fs_spacing: gap=%0d want %0d", p - last_idx, TOTAL);
                end
                last_idx = p;
            end
        end
        n_vec++;
        if (fs_seen != 3) begin
            n_err++;
            $display("FAIL fs_count: got %0d pulses want 3", fs_seen);
        end
    endtask

    task automatic test_spacing;
        int start;
        start = m_cnt;
        for (int p = 0; p < 3; p++) begin
            step(1'b1);
            for (int i = 0; i < 799; i++) begin
                step(1'b0);
                n_vec++;
                if (V_Counts !== CNT_W'(m_cnt) || frame_start !== 1'b0 ||
                    Display_Row !== CNT_W'(exp_row(m_cnt))) begin
                    n_err++;
                    $display("FAIL spaced_hold: cnt=%0d row=%0d fs=%b want %0d/%0d/0",
                             V_Counts, Display_Row, frame_start, m_cnt, exp_row(m_cnt));
                end
            end
        end
        n_vec++;
        if (V_Counts !== CNT_W'((start + 3) % TOTAL)) begin
            n_err++;
            $display("FAIL spaced_adv: cnt=%0d want %0d", V_Counts, (start + 3) % TOTAL);
        end
    endtask

    task automatic test_back_to_back;
        int start;
        start = m_cnt;
        for (int i = 0; i < 4; i++) step(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            n_vec++;
            if (V_Counts !== CNT_W'((start + 4) % TOTAL)) begin
                n_err++;
                $display("FAIL b2b_adv: cnt=%0d want %0d", V_Counts, (start + 4) % TOTAL);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            n_vec++;
            if (V_Counts !== CNT_W'(m_cnt) || v_phase !== 2'(exp_phase(m_cnt)) ||
                VSYNC !== (exp_phase(m_cnt) != 0) || v_active !== (exp_phase(m_cnt) == 2) ||
                Display_Row !== CNT_W'(exp_row(m_cnt)) || frame_start !== m_fs) begin
                n_err++;
                $display("FAIL random: cnt=%0d ph=%0d vs=%b act=%b row=%0d fs=%b want cnt=%0d ph=%0d row=%0d fs=%b",
                         V_Counts, v_phase, VSYNC, v_active, Display_Row, frame_start,
                         m_cnt, exp_phase(m_cnt), exp_row(m_cnt), m_fs);
            end
        end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < TOTAL && m_cnt != 300; i++) step(1'b1);
        line_end = 1'b0;
        n_vec++;
        if (V_Counts !== 10'd300 || v_active !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: cnt=%0d act=%b want 300/1", V_Counts, v_active);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (V_Counts !== '0 || VSYNC !== 1'b0 || v_phase !== 2'd0 ||
            v_active !== 1'b0 || Display_Row !== '0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: cnt=%0d vs=%b ph=%0d act=%b row=%0d fs=%b want all 0",
                     V_Counts, VSYNC, v_phase, v_active, Display_Row, frame_start);
        end
        step(1'b0);
        #2;
        rst_n = 1'b1;
        step(1'b1);
        n_vec++;
        if (V_Counts !== 10'd1 || v_phase !== 2'd0 || VSYNC !== 1'b0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: cnt=%0d ph=%0d vs=%b fs=%b want 1/0/0/0",
                     V_Counts, v_phase, VSYNC, frame_start);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        line_end = 1'b0;
        #3;
        test_reset();
        test_porch_edges();
        test_display_span();
        test_wrap();
        test_spacing();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
